// File: rtl/nmk112_pkg.sv
// nmk112_pkg: shared constants and FSM state type for the NMK112 PCM arbiter
package nmk112_pkg;
    localparam logic [10:0] TABLE_LIMIT = 11'h400;
    localparam int WIN_BITS = 2;
    localparam int BANK_W = 8;
    typedef enum logic {IDLE, WAIT} arb_state_t;
endpackage

// File: rtl/nmk112_xlate.sv
// nmk112_xlate: per-chip window/bank translation with optional phoneme-table paging
module nmk112_xlate
    import nmk112_pkg::*;
#(
    parameter int AW_OKI = 18,
    parameter int AW_ROM = 22,
    parameter logic [AW_ROM-1:0] BASE = '0,
    parameter bit PAGED = 1'b0
) (
    input  logic [(1<<WIN_BITS)*BANK_W-1:0] banks,
    input  logic [AW_OKI-1:0] addr,
    output logic [AW_ROM-1:0] rom_addr
);
    logic [WIN_BITS-1:0] win;
    logic [BANK_W-1:0] bank;
    // low table addresses take their window from a[9:8] when paging is on
    always_comb begin
        win = (PAGED && addr < AW_OKI'(TABLE_LIMIT)) ? addr[9:8] : addr[AW_OKI-1 -: WIN_BITS];
        bank = banks[win*BANK_W +: BANK_W];
        rom_addr = BASE + AW_ROM'({bank, addr[15:0]});
    end
endmodule

// File: rtl/nmk112_pcm_arbiter.sv
// nmk112_pcm_arbiter: NMK112 bank mapper with round-robin ROM arbitration and a one-entry hit cache per chip
module nmk112_pcm_arbiter
    import nmk112_pkg::*;
#(
    parameter int NCHIP = 2,
    parameter int AW_OKI = 18,
    parameter int AW_ROM = 22,
    parameter logic [AW_ROM-1:0] CHIP_STRIDE = 22'h100000,
    parameter logic [3:0] PAGE_MASK = 4'b0000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic bank_we,
    input  logic [3:0] bank_sel,
    input  logic [7:0] bank_din,
    input  logic [NCHIP*AW_OKI-1:0] req_addr,
    output logic [NCHIP*8-1:0] req_data,
    output logic [NCHIP-1:0] req_ok,
    output logic rom_cs,
    output logic [AW_ROM-1:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic rom_ok
);
    localparam int CW = (NCHIP > 1) ? $clog2(NCHIP) : 1;
    localparam int NWIN = 1 << WIN_BITS;

    logic [NCHIP-1:0][NWIN*BANK_W-1:0] bank;
    logic [NCHIP-1:0][AW_OKI-1:0] ra, lat;
    logic [NCHIP-1:0][AW_ROM-1:0] xa;
    logic [NCHIP-1:0][7:0] data;
    logic [NCHIP-1:0] valid, wr_chip;
    arb_state_t state, state_n;
    logic [CW-1:0] cur, ptr, pick, idx, ptr_nxt;
    logic [AW_OKI-1:0] cap;
    logic found, first, abrt, abort_now, done;

    assign ra = req_addr;
    assign req_data = data;

    for (genvar k = 0; k < NCHIP; k++) begin : g_chip
        nmk112_xlate #(
            .AW_OKI(AW_OKI),
            .AW_ROM(AW_ROM),
            .BASE(AW_ROM'(k * CHIP_STRIDE)),
            .PAGED(PAGE_MASK[k])
        ) u_xlate (
            .banks(bank[k]),
            .addr(ra[k]),
            .rom_addr(xa[k])
        );
        assign req_ok[k] = valid[k] && ra[k] == lat[k];
        assign wr_chip[k] = bank_we && bank_sel[3:2] == 2'(k);
    end

    // round-robin search from ptr for the first chip whose cache misses
    always_comb begin
        found = 1'b0;
        pick = ptr;
        idx = '0;
        for (int i = NCHIP - 1; i >= 0; i--) begin
            idx = CW'((int'(ptr) + i) % NCHIP);
            if (!req_ok[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end

    // next state: leave IDLE on any miss, leave WAIT on a rom_ok past the stale first cycle
    always_comb begin
        abort_now = ra[cur] != cap || wr_chip[cur];
        done = state == WAIT && !first && rom_ok;
        ptr_nxt = (cur == CW'(NCHIP - 1)) ? '0 : cur + 1'b1;
        state_n = (state == IDLE) ? (found ? WAIT : IDLE) : (done ? IDLE : WAIT);
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else state <= state_n;
    end

    // bank file, reset to the linear mapping; writes to absent chips fall through
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NCHIP; k++)
                for (int w = 0; w < NWIN; w++)
                    bank[k][w*BANK_W +: BANK_W] <= BANK_W'(w);
        end else begin
            for (int k = 0; k < NCHIP; k++)
                if (wr_chip[k]) bank[k][bank_sel[1:0]*BANK_W +: BANK_W] <= bank_din;
        end
    end

    // fetch bookkeeping and cache fill; a bank write to a chip always beats its fill
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cur <= '0;
            ptr <= '0;
            cap <= '0;
            first <= 1'b0;
            abrt <= 1'b0;
            rom_cs <= 1'b0;
            rom_addr <= '0;
            valid <= '0;
            lat <= '0;
            data <= '0;
        end else begin
            if (state == IDLE && found) begin
                cur <= pick;
                cap <= ra[pick];
                rom_addr <= xa[pick];
                rom_cs <= 1'b1;
                first <= 1'b1;
                abrt <= wr_chip[pick];
                valid[pick] <= 1'b0;
            end
            if (state == WAIT) begin
                first <= 1'b0;
                abrt <= abrt || abort_now;
                if (done) begin
                    rom_cs <= 1'b0;
                    ptr <= ptr_nxt;
                    if (!(abrt || abort_now)) begin
                        data[cur] <= rom_data;
                        lat[cur] <= cap;
                        valid[cur] <= 1'b1;
                    end
                end
            end
            for (int k = 0; k < NCHIP; k++)
                if (wr_chip[k]) valid[k] <= 1'b0;
        end
    end
endmodule
